// File: rtl/fft_frame_sched_if.sv
// Magnitude bus from the FFT/CORDIC chain into the frame scheduler.
interface fft_frame_sched_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned MAG_W  = 16
);

  logic              fft_magni_valid;
  logic [MAG_W-1:0]  fft_magni_data;
  logic [ADDR_W-1:0] fft_magni_addr;

  // Producer side (FFT chain / testbench driver)
  modport master (
    output fft_magni_valid,
    output fft_magni_data,
    output fft_magni_addr
  );

  // Consumer side (frame scheduler)
  modport slave (
    input  fft_magni_valid,
    input  fft_magni_data,
    input  fft_magni_addr
  );

endinterface

// File: rtl/fft_frame_sched.sv
// Frame sequencer for the FFT magnitude chain: gates one N_FFT-sample frame
// into the FFT, scans the returned magnitudes for the peak bin and reports it.
module fft_frame_sched #(
  parameter int unsigned N_FFT   = 1024,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned MAG_W   = 16,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic                sys_clk,
  input  logic                sys_rstn,
  input  logic                start_req,
  input  logic                cont_mode,
  input  logic                s_adc_valid,
  output logic                fft_adc_valid,
  fft_frame_sched_if.slave    magni_if,
  output logic                busy,
  output logic                peak_valid,
  output logic [ADDR_W-1:0]   peak_addr,
  output logic [MAG_W-1:0]    peak_magni,
  output logic                timeout_err
);

  localparam int unsigned LOG2N = $clog2(N_FFT);
  localparam int unsigned CNT_W = LOG2N + 1;
  localparam int unsigned TMR_W = 16;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_FFT - 1);
  localparam logic [LOG2N-1:0] BIN_HALF = LOG2N'(N_FFT / 2);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_WAIT,
    S_SCAN,
    S_DONE
  } state_e;

  state_e              state_q,      state_d;
  logic [CNT_W-1:0]    cnt_q,        cnt_d;
  logic [TMR_W-1:0]    timer_q,      timer_d;
  logic [MAG_W-1:0]    best_magni_q, best_magni_d;
  logic [ADDR_W-1:0]   best_addr_q,  best_addr_d;
  logic [MAG_W-1:0]    peak_magni_q, peak_magni_d;
  logic [ADDR_W-1:0]   peak_addr_q,  peak_addr_d;
  logic                peak_valid_q, peak_valid_d;
  logic                timeout_q,    timeout_d;
  logic                busy_q,       busy_d;

  logic [LOG2N-1:0]    bin_c;
  logic                cand_c;

  // Bin index within one transform; DC and the mirrored upper half never win.
  assign bin_c  = magni_if.fft_magni_addr[LOG2N-1:0];
  assign cand_c = (bin_c != '0) && (bin_c < BIN_HALF);

  // Sample strobe passes only while a frame is being fed.
  assign fft_adc_valid = s_adc_valid && (state_q == S_FEED);

  assign busy        = busy_q;
  assign peak_valid  = peak_valid_q;
  assign peak_addr   = peak_addr_q;
  assign peak_magni  = peak_magni_q;
  assign timeout_err = timeout_q;

  // State and datapath registers.
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      timer_q      <= '0;
      best_magni_q <= '0;
      best_addr_q  <= '0;
      peak_magni_q <= '0;
      peak_addr_q  <= '0;
      peak_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      timer_q      <= timer_d;
      best_magni_q <= best_magni_d;
      best_addr_q  <= best_addr_d;
      peak_magni_q <= peak_magni_d;
      peak_addr_q  <= peak_addr_d;
      peak_valid_q <= peak_valid_d;
      timeout_q    <= timeout_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state, counters, peak search and result/pulse generation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    timer_d      = timer_q;
    best_magni_d = best_magni_q;
    best_addr_d  = best_addr_q;
    peak_magni_d = peak_magni_q;
    peak_addr_d  = peak_addr_q;
    peak_valid_d = 1'b0;
    timeout_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_req || cont_mode) begin
          cnt_d   = '0;
          state_d = S_FEED;
        end
      end

      S_FEED: begin
        if (s_adc_valid) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d        = '0;
            best_magni_d = '0;
            best_addr_d  = ADDR_W'(1);
            timer_d      = '0;
            state_d      = S_WAIT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_WAIT, S_SCAN: begin
        if (magni_if.fft_magni_valid) begin
          timer_d = '0;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_SCAN;
          // Strict compare keeps the earliest bin on ties.
          if (cand_c && (magni_if.fft_magni_data > best_magni_q)) begin
            best_magni_d = magni_if.fft_magni_data;
            best_addr_d  = magni_if.fft_magni_addr;
          end
          if (cnt_q == CNT_LAST) begin
            peak_magni_d = best_magni_d;
            peak_addr_d  = best_addr_d;
            peak_valid_d = 1'b1;
            state_d      = S_DONE;
          end
        end else if (timer_q >= TMR_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else if (timer_q != TMR_MAX) begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      S_DONE: begin
        cnt_d   = '0;
        state_d = cont_mode ? S_FEED : S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_fft_frame_sched.sv
// Scoreboard bench for fft_frame_sched: frames are driven from a magnitude
// table, a reference peak search pushes the expected result, a monitor pops
// and compares on each peak_valid / timeout_err pulse.
module tb_fft_frame_sched;

  localparam int unsigned N       = 1024;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned MAG_W   = 16;
  localparam int unsigned TIMEOUT = 2000;

  typedef struct {
    bit is_to;
    int addr;
    int magni;
    int cyc;
  } exp_t;

  logic              sys_clk;
  logic              sys_rstn;
  logic              start_req;
  logic              cont_mode;
  logic              s_adc_valid;
  logic              fft_adc_valid;
  logic              busy;
  logic              peak_valid;
  logic [ADDR_W-1:0] peak_addr;
  logic [MAG_W-1:0]  peak_magni;
  logic              timeout_err;

  fft_frame_sched_if #(.ADDR_W(ADDR_W), .MAG_W(MAG_W)) mif ();

  fft_frame_sched #(
    .N_FFT   (N),
    .ADDR_W  (ADDR_W),
    .MAG_W   (MAG_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rstn      (sys_rstn),
    .start_req     (start_req),
    .cont_mode     (cont_mode),
    .s_adc_valid   (s_adc_valid),
    .fft_adc_valid (fft_adc_valid),
    .magni_if      (mif),
    .busy          (busy),
    .peak_valid    (peak_valid),
    .peak_addr     (peak_addr),
    .peak_magni    (peak_magni),
    .timeout_err   (timeout_err)
  );

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   mag [N];
  exp_t sb [$];
  exp_t e_m;
  int   last_addr  = 0;
  int   last_magni = 0;

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // Single comparison point for the whole bench.
  task automatic chk(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Monitor: every result/error pulse must match the head of the scoreboard.
  initial begin
    forever begin
      @(posedge sys_clk);
      cyc++;
      #1;
      if (peak_valid || timeout_err) begin
        if (sb.size() == 0) begin
          chk("unexpected_event", 1, 0);
        end else begin
          e_m = sb.pop_front();
          chk("event_kind", longint'(timeout_err), longint'(e_m.is_to));
          chk("event_cycle", cyc, e_m.cyc);
          if (!e_m.is_to) begin
            chk("peak_addr", peak_addr, e_m.addr);
            chk("peak_magni", peak_magni, e_m.magni);
            last_addr  = e_m.addr;
            last_magni = e_m.magni;
          end else begin
            chk("to_peak_addr_hold", peak_addr, last_addr);
            chk("to_peak_magni_hold", peak_magni, last_magni);
            chk("to_busy", busy, 0);
          end
        end
      end
    end
  end

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // Fill the magnitude table with one of the test patterns.
  task automatic build(input int p);
    for (int a = 0; a < N; a++) begin
      case (p)
        0:       mag[a] = 5;
        1:       mag[a] = 7;
        2:       mag[a] = 0;
        3:       mag[a] = int'($urandom_range(0, 99));
        default: mag[a] = int'($urandom_range(0, 65535));
      endcase
    end
    case (p)
      0: begin mag[0] = 900;  mag[37] = 800; end
      1: begin mag[12] = 300; mag[40] = 300; end
      3: begin mag[0] = 3000; mag[511] = 400; mag[512] = 1000; mag[1023] = 2000; end
      default: ;
    endcase
  endtask

  // Drive n contiguous ADC strobes and count how many reach the FFT.
  task automatic feed(input int n, input bit stale, input int exp_gated);
    int g;
    g = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      s_adc_valid = 1'b1;
      if (stale) begin
        mif.fft_magni_valid = 1'b1;
        mif.fft_magni_data  = MAG_W'(60000);
        mif.fft_magni_addr  = ADDR_W'(5);
      end
      #1;
      if (fft_adc_valid) g++;
    end
    @(negedge sys_clk);
    s_adc_valid         = 1'b0;
    mif.fft_magni_valid = 1'b0;
    chk("gated_strobes", g, exp_gated);
  endtask

  // Drive nb magnitude beats from the table; push the expected outcome.
  task automatic send_mags(input int nb, input bit push);
    int   best;
    int   baddr;
    exp_t e;
    best  = 0;
    baddr = 1;
    for (int a = 1; a < N / 2; a++) begin
      if (mag[a] > best) begin
        best  = mag[a];
        baddr = a;
      end
    end
    for (int a = 0; a < nb; a++) begin
      @(negedge sys_clk);
      mif.fft_magni_valid = 1'b1;
      mif.fft_magni_data  = MAG_W'(mag[a]);
      mif.fft_magni_addr  = ADDR_W'(a);
    end
    if (push) begin
      e.is_to = (nb != N);
      e.addr  = baddr;
      e.magni = best;
      e.cyc   = (nb == N) ? cyc + 1 : cyc + 1 + int'(TIMEOUT);
      sb.push_back(e);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  // One single-shot measurement with a given pattern.
  task automatic run_single(input int p, input bit stale);
    @(negedge sys_clk);
    start_req = 1'b1;
    @(negedge sys_clk);
    start_req = 1'b0;
    feed(N, stale, N);
    build(p);
    send_mags(N, 1'b1);
    @(negedge sys_clk);
    mif.fft_magni_valid = 1'b0;
    wait_drain(20);
    @(negedge sys_clk);
    #1;
    chk("idle_after_single", busy, 0);
  endtask

  initial begin
    sys_rstn            = 1'b1;
    start_req           = 1'b0;
    cont_mode           = 1'b0;
    s_adc_valid         = 1'b0;
    mif.fft_magni_valid = 1'b0;
    mif.fft_magni_data  = '0;
    mif.fft_magni_addr  = '0;
    #2;
    sys_rstn = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_peak_valid", peak_valid, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_peak_addr", peak_addr, 0);
    chk("rst_peak_magni", peak_magni, 0);
    chk("rst_adc_gate", fft_adc_valid, 0);
    repeat (3) @(negedge sys_clk);
    sys_rstn = 1'b1;

    // Start, strobes in IDLE dropped, 1500 strobes -> exactly N pass.
    @(negedge sys_clk);
    start_req   = 1'b1;
    s_adc_valid = 1'b1;
    #1;
    chk("idle_gate", fft_adc_valid, 0);
    chk("idle_busy", busy, 0);
    @(negedge sys_clk);
    start_req   = 1'b0;
    s_adc_valid = 1'b0;
    #1;
    chk("busy_after_start", busy, 1);
    feed(1500, 1'b0, N);
    chk("busy_in_wait", busy, 1);
    // start_req while busy is ignored.
    @(negedge sys_clk);
    start_req = 1'b1;
    @(negedge sys_clk);
    start_req = 1'b0;
    build(0);
    send_mags(N, 1'b1);
    @(negedge sys_clk);
    mif.fft_magni_valid = 1'b0;
    wait_drain(20);
    @(negedge sys_clk);
    #1;
    chk("no_queued_start", busy, 0);
    feed(10, 1'b0, 0);

    // Tie, all-zero (with stale beats during FEED), bin boundaries.
    run_single(1, 1'b0);
    run_single(2, 1'b1);
    run_single(3, 1'b0);

    // Continuous mode: three back-to-back frames.
    @(negedge sys_clk);
    cont_mode = 1'b1;
    for (int f = 0; f < 3; f++) begin
      feed(N + 6, 1'b0, N);
      build((f == 1) ? 3 : 4);
      if (f == 2) cont_mode = 1'b0;
      send_mags(N, 1'b1);
      @(negedge sys_clk);
      mif.fft_magni_valid = 1'b0;
      s_adc_valid         = 1'b1;
      #1;
      chk("done_adc_gated", fft_adc_valid, 0);
      chk("done_busy", busy, 1);
      @(negedge sys_clk);
      #1;
      chk("refeed_gate", fft_adc_valid, (f < 2) ? 1 : 0);
      chk("refeed_busy", busy, (f < 2) ? 1 : 0);
      s_adc_valid = 1'b0;
    end
    wait_drain(20);

    // Timeout after 500 beats, with cont_mode set.
    @(negedge sys_clk);
    cont_mode = 1'b1;
    feed(N, 1'b0, N);
    build(4);
    send_mags(500, 1'b1);
    @(negedge sys_clk);
    mif.fft_magni_valid = 1'b0;
    wait_drain(int'(TIMEOUT) + 100);
    @(negedge sys_clk);
    cont_mode = 1'b0;

    // DUT re-entered FEED; run into SCAN then reset mid-frame.
    feed(N, 1'b0, N);
    build(0);
    send_mags(300, 1'b0);
    @(negedge sys_clk);
    mif.fft_magni_valid = 1'b0;
    s_adc_valid         = 1'b1;
    sys_rstn            = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_peak_addr", peak_addr, 0);
    chk("mid_rst_peak_magni", peak_magni, 0);
    chk("mid_rst_adc_gate", fft_adc_valid, 0);
    last_addr  = 0;
    last_magni = 0;
    repeat (3) @(negedge sys_clk);
    s_adc_valid = 1'b0;
    sys_rstn    = 1'b1;
    feed(20, 1'b1, 0);
    #1;
    chk("post_rst_idle", busy, 0);

    // A fresh start works normally after reset.
    run_single(0, 1'b0);
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
